// File: rtl/repeated_subtractor.sv
// repeated_subtractor: sequential unsigned divider built from repeated
// subtraction, one subtraction per enabled clock cycle. A start in IDLE
// captures the operands. The quotient and remainder are held until the next
// result. A zero divisor finishes after one cycle with an all-ones quotient
// and the div_by_zero flag set.
// Optional build macro: REPEATED_SUBTRACTOR_ROUND_EN rounds the quotient
// up when the final remainder is at least half the divisor.
module repeated_subtractor #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r, state_s;
  logic [W-1:0] r_r, r_s;
  logic [W-1:0] b_r, b_s;
  logic [W-1:0] q_r, q_s;
  logic [W-1:0] quotient_r, quotient_s;
  logic [W-1:0] remainder_r, remainder_s;
  logic         busy_r, busy_s;
  logic         done_r, done_s;
  logic         dz_r, dz_s;
  logic [W-1:0] q_final_s;

`ifdef REPEATED_SUBTRACTOR_ROUND_EN
  logic [W:0]   r_twice_s;
  logic [W-1:0] q_inc_s;

  // Round half up on exit: compare 2*r with b one bit wider so nothing is lost.
  always_comb begin
    r_twice_s = {r_r, 1'b0};
    q_inc_s   = q_r + {{(W-1){1'b0}}, 1'b1};
    if (r_twice_s >= {1'b0, b_r}) begin
      if (q_r == {W{1'b1}}) begin
        q_final_s = {W{1'b1}};
      end else begin
        q_final_s = q_inc_s;
      end
    end else begin
      q_final_s = q_r;
    end
  end
`else
  // Truncating division: the final quotient is the subtraction count.
  always_comb begin
    q_final_s = q_r;
  end
`endif

  // Next-state and next-output logic; everything holds while ena is low.
  always_comb begin
    state_s     = state_r;
    r_s         = r_r;
    b_s         = b_r;
    q_s         = q_r;
    quotient_s  = quotient_r;
    remainder_s = remainder_r;
    dz_s        = dz_r;
    if (ena) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            r_s  = dividend;
            b_s  = divisor;
            q_s  = {W{1'b0}};
            dz_s = 1'b0;
            if (divisor == {W{1'b0}}) begin
              state_s     = DONE;
              quotient_s  = {W{1'b1}};
              remainder_s = dividend;
              dz_s        = 1'b1;
            end else begin
              state_s = SUB;
            end
          end else begin
            state_s = IDLE;
          end
        end
        SUB: begin
          // b >= 1 here, so q can never wrap.
          if (r_r >= b_r) begin
            r_s = r_r - b_r;
            q_s = q_r + {{(W-1){1'b0}}, 1'b1};
          end else begin
            quotient_s  = q_final_s;
            remainder_s = r_r;
            state_s     = DONE;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Status flags are decoded from the next state so they arrive registered.
  always_comb begin
    busy_s = (state_s == SUB) || (state_s == DONE);
    done_s = (state_s == DONE);
  end

  // State and result registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      r_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      q_r         <= {W{1'b0}};
      quotient_r  <= {W{1'b0}};
      remainder_r <= {W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dz_r        <= 1'b0;
    end else begin
      state_r     <= state_s;
      r_r         <= r_s;
      b_r         <= b_s;
      q_r         <= q_s;
      quotient_r  <= quotient_s;
      remainder_r <= remainder_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      dz_r        <= dz_s;
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dz_r;

endmodule

// File: tb/tb_repeated_subtractor.sv
// Self-checking bench for repeated_subtractor. Expected results come from
// plain integer division; expected timing from the documented latency
// (Q+2 cycles, 1 cycle for a zero divisor, plus any ena-low cycles).
module tb_repeated_subtractor;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  repeated_subtractor #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One division: operands a/b, optional ena-low window of gap_len cycles
  // starting at cycle gap_at, optional ignored start re-pulse at cycle rp.
  task automatic run_div(input int a, input int b, input int gap_at,
                         input int gap_len, input int rp);
    int exp_q, exp_r, exp_lat, done_cyc;
    bit exp_dz;
    if (b == 0) begin
      exp_q = (1 << W) - 1;
      exp_r = a;
      exp_dz = 1'b1;
      exp_lat = 1;
    end else begin
      exp_q = a / b;
      exp_r = a % b;
      exp_dz = 1'b0;
      exp_lat = exp_q + 2;
`ifdef REPEATED_SUBTRACTOR_ROUND_EN
      if (2 * exp_r >= b) exp_q = (exp_q + 1 > (1 << W) - 1) ? (1 << W) - 1 : exp_q + 1;
`endif
    end
    done_cyc = exp_lat + gap_len;
    dividend = a[W-1:0];
    divisor  = b[W-1:0];
    start    = 1'b1;
    ena      = 1'b1;
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      next_cycle();
      if (cyc == 1) start = 1'b0;
      if (rp != 0 && cyc == rp) begin
        start = 1'b1; dividend = 6'd60; divisor = 6'd2;
      end
      if (rp != 0 && cyc == rp + 1) start = 1'b0;
      if (gap_len != 0 && cyc == gap_at) ena = 1'b0;
      if (gap_len != 0 && cyc == gap_at + gap_len) ena = 1'b1;
      chk("busy", busy, (cyc <= done_cyc));
      chk("done", done, (cyc == done_cyc));
      chk("div_by_zero", div_by_zero, exp_dz);
      if (cyc >= done_cyc) begin
        chk("quotient", quotient, exp_q);
        chk("remainder", remainder, exp_r);
      end
    end
    ena = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    int a, b, gl, ga, lat;
    // Reset state.
    #12;
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    rst_n = 1'b1;
    ena = 1'b1;
    next_cycle();

    // Directed cases.
    run_div(45, 7, 0, 0, 0);     // done cycle 8, 6 r3
    run_div(47, 7, 0, 0, 0);     // 6 (7 rounded) r5
    run_div(63, 1, 0, 0, 0);     // done cycle 65
    run_div(5, 9, 0, 0, 0);      // done cycle 2
    run_div(20, 0, 0, 0, 0);     // divide by zero, done cycle 1
    run_div(45, 7, 4, 3, 0);     // div_by_zero clears; ena gap -> done cycle 11
    run_div(45, 7, 0, 0, 3);     // start re-pulsed while busy is ignored
    run_div(5, 9, 0, 0, 2);      // start in the DONE cycle is ignored
    run_div(0, 5, 0, 0, 0);      // zero dividend
    run_div(63, 63, 0, 0, 0);    // equal operands

    // Randomized operands with random ena gaps.
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 63);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
      lat = (b == 0) ? 1 : (a / b) + 2;
      gl = 0;
      ga = 0;
      if (lat > 2 && $urandom_range(0, 1) == 1) begin
        ga = $urandom_range(1, lat - 1);
        gl = $urandom_range(1, 4);
      end
      run_div(a, b, ga, gl, 0);
    end

    // Reset mid-SUB: outputs clear at once and no done pulse follows.
    dividend = 6'd63;
    divisor  = 6'd1;
    start    = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      next_cycle();
      if (cyc == 1) start = 1'b0;
    end
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_quotient", quotient, 0);
    chk("mid_rst_remainder", remainder, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_dz", div_by_zero, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      next_cycle();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

    // Device still works after the abort.
    run_div(45, 7, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
